// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: power-of-two byte FIFO feeding an 8N1 UART transmitter.
// Bytes enter on a valid/ready handshake and leave LSB first.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 868,
  parameter int ADDR_W       = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [7:0]      byte_in,
  input  logic            byte_valid,
  output logic            byte_ready,
  output logic            serial_out,
  output logic            busy,
  output logic [ADDR_W:0] fifo_count
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [ADDR_W:0] FULL =
    (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE, START, DATA, STOP
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W-1:0] rptr_q, rptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              serial_q, serial_d;
  logic              busy_q, busy_d;
  logic [7:0]        mem_q [DEPTH];
  logic              push, pop, tick;

  assign byte_ready = (count_q != FULL);
  assign fifo_count = count_q;
  assign serial_out = serial_q;
  assign busy       = busy_q;

  always_comb begin
    push   = byte_valid && byte_ready;
    pop    = (state_q == IDLE) && (count_q != '0);
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push) wptr_d = wptr_q + ADDR_W'(1);
    if (pop)  rptr_d = rptr_q + ADDR_W'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + (ADDR_W+1)'(1);
      2'b01:   count_d = count_q - (ADDR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= byte_in;
  end

  always_comb begin
    tick    = (cnt_q == '0);
    state_d = state_q;
    cnt_d   = cnt_q - CNT_W'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = cnt_q;
        if (pop) begin
          state_d = START;
          cnt_d   = CNT_MAX;
          shift_d = mem_q[rptr_q];
        end
      end
      START: begin
        if (tick) begin
          state_d = DATA;
          cnt_d   = CNT_MAX;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (tick) begin
          cnt_d   = CNT_MAX;
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (tick) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
    endcase
  end

  // Line and busy both follow the registered state, so busy covers
  // the whole visible stop bit.
  always_comb begin
    serial_d = 1'b1;
    unique case (state_q)
      IDLE:  serial_d = 1'b1;
      START: serial_d = 1'b0;
      DATA:  serial_d = shift_q[0];
      STOP:  serial_d = 1'b1;
    endcase
    busy_d = (state_q != IDLE) || (count_q != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      serial_q <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      serial_q <= serial_d;
      busy_q   <= busy_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: scoreboard bench for the buffered UART transmitter.
// A line decoder on the fast instance pops expected bytes from a queue.
module tb_uart_tx_fifo;
  localparam int CPB = 4;
  localparam int AW  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [7:0]  bi4, bi2, bi8;
  logic        bv4, bv2, bv8;
  logic        br4, br2, br8;
  logic        so4, so2, so8;
  logic        by4, by2, by8;
  logic [AW:0] fc4, fc2, fc8;

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .ADDR_W(AW)) u4 (
    .clk(clk), .rst_n(rst_n), .byte_in(bi4),
    .byte_valid(bv4), .byte_ready(br4),
    .serial_out(so4), .busy(by4), .fifo_count(fc4)
  );
  uart_tx_fifo #(.CLKS_PER_BIT(2), .ADDR_W(AW)) u2 (
    .clk(clk), .rst_n(rst_n), .byte_in(bi2),
    .byte_valid(bv2), .byte_ready(br2),
    .serial_out(so2), .busy(by2), .fifo_count(fc2)
  );
  uart_tx_fifo #(.CLKS_PER_BIT(868), .ADDR_W(AW)) u8 (
    .clk(clk), .rst_n(rst_n), .byte_in(bi8),
    .byte_valid(bv8), .byte_ready(br8),
    .serial_out(so8), .busy(by8), .fifo_count(fc8)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rst_cnt = 0;
  logic [7:0] exp_q[$];
  int start_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge rst_n) rst_cnt++;

  // Decoder: samples mid-bit; frames cut by reset are dropped.
  initial begin : monitor
    logic prev, st, sp;
    logic [7:0] b, e;
    int rc;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (rst_n && prev && !so4) begin
        rc = rst_cnt;
        start_cyc.push_back(cyc);
        repeat (CPB / 2) @(negedge clk);
        st = so4;
        for (int j = 0; j < 8; j++) begin
          repeat (CPB) @(negedge clk);
          b[j] = so4;
        end
        repeat (CPB) @(negedge clk);
        sp = so4;
        if (rc == rst_cnt && rst_n) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL frame_unexpected got=%02h want=none", b);
          end else begin
            e = exp_q.pop_front();
            if ({sp, b, st} !== {1'b1, e, 1'b0}) begin
              failures++;
              $display("FAIL frame got=%02h st=%b sp=%b want=%02h",
                       b, st, sp, e);
            end
          end
        end
      end
      prev = so4;
    end
  end

  initial begin : watchdog
    repeat (80000) @(posedge clk);
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic line(input int sel);
    return (sel == 2) ? so2 : so8;
  endfunction

  task automatic wait_drain(input string nm, input int limit);
    int n = 0;
    while ((by4 || exp_q.size() != 0) && n < limit) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    checks++;
    if (n >= limit || exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_drain got=left%0d busy=%b want=empty",
               nm, exp_q.size(), by4);
    end
  endtask

  task automatic test_reset();
    int bad = 0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({so4, by4, br4, fc4} !== {3'b101, 5'd0}) begin
      failures++;
      $display("FAIL reset_async got=%b%b%b/%0d want=101/0",
               so4, by4, br4, fc4);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if ({so4, by4, br4, fc4} !== {3'b101, 5'd0}) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL reset_idle got=%0d bad cycles want=0", bad);
    end
  endtask

  task automatic test_single();
    logic [7:0] d;
    logic es, eb;
    int bad = 0;
    d = 8'h55;
    @(negedge clk);
    bi4 = d;
    bv4 = 1'b1;
    exp_q.push_back(d);
    @(negedge clk);
    bv4 = 1'b0;
    bi4 = 8'h00;
    checks++;
    if (fc4 !== 5'd1) begin
      failures++;
      $display("FAIL single_count0 got=%0d want=1", fc4);
    end
    for (int k = 0; k < 46; k++) begin
      if (k < 2)       es = 1'b1;
      else if (k < 6)  es = 1'b0;
      else if (k < 38) es = d[(k - 6) / 4];
      else             es = 1'b1;
      eb = (k >= 1 && k <= 41);
      if (so4 !== es || by4 !== eb) begin
        bad++;
        $display("FAIL single_wave k=%0d got=%b/%b want=%b/%b",
                 k, so4, by4, es, eb);
      end
      if (k == 1) begin
        checks++;
        if (fc4 !== 5'd0) begin
          failures++;
          $display("FAIL single_pop got=%0d want=0", fc4);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (bad != 0) failures++;
    wait_drain("single", 100);
  endtask

  task automatic test_back_to_back();
    logic [7:0] v [3];
    logic [4:0] ec [3];
    v  = '{8'h00, 8'hFF, 8'hA3};
    ec = '{5'd1, 5'd1, 5'd2};
    start_cyc.delete();
    @(negedge clk);
    bv4 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bi4 = v[i];
      exp_q.push_back(v[i]);
      @(negedge clk);
      checks++;
      if (fc4 !== ec[i]) begin
        failures++;
        $display("FAIL b2b_count%0d got=%0d want=%0d", i, fc4, ec[i]);
      end
    end
    bv4 = 1'b0;
    wait_drain("b2b", 400);
    checks++;
    if (start_cyc.size() != 3) begin
      failures++;
      $display("FAIL b2b_starts got=%0d want=3", start_cyc.size());
    end else begin
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (start_cyc[i] - start_cyc[i-1] != 41) begin
          failures++;
          $display("FAIL b2b_period got=%0d want=41",
                   start_cyc[i] - start_cyc[i-1]);
        end
      end
    end
  endtask

  task automatic test_full();
    logic acc;
    bit full_seen = 0;
    int pushes = 0, win = 0, bad = 0;
    @(negedge clk);
    bi4 = 8'h10;
    bv4 = 1'b1;
    for (int c = 0; c < 230; c++) begin
      if (fc4 > 5'd16 || br4 !== (fc4 != 5'd16)) bad++;
      if (fc4 == 5'd16) full_seen = 1;
      acc = br4;
      if (acc) exp_q.push_back(bi4);
      if (full_seen) begin
        if (acc && win < 164) pushes++;
        win++;
      end
      @(negedge clk);
      if (acc) bi4 = bi4 + 8'd1;
    end
    bv4 = 1'b0;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL full_ready got=%0d bad cycles want=0", bad);
    end
    checks++;
    if (!full_seen) begin
      failures++;
      $display("FAIL full_reach got=no want=count16");
    end
    checks++;
    if (pushes != 4) begin
      failures++;
      $display("FAIL full_refill got=%0d pushes want=4", pushes);
    end
    wait_drain("full", 2000);
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    @(negedge clk);
    bv4 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bi4 = 8'hC0 + 8'(i);
      exp_q.push_back(bi4);
      @(negedge clk);
    end
    bv4 = 1'b0;
    repeat (15) @(negedge clk);
    checks++;
    if (fc4 !== 5'd4) begin
      failures++;
      $display("FAIL rstmid_pre got=%0d want=4", fc4);
    end
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    checks++;
    if ({so4, by4, br4, fc4} !== {3'b101, 5'd0}) begin
      failures++;
      $display("FAIL rstmid_abort got=%b%b%b/%0d want=101/0",
               so4, by4, br4, fc4);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if ({so4, by4, fc4} !== {2'b10, 5'd0}) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL rstmid_quiet got=%0d bad cycles want=0", bad);
    end
  endtask

  task automatic test_bit_period(input int sel, input logic [7:0] b);
    logic [9:0] fr;
    int n = 0, bad = 0;
    fr = {1'b1, b, 1'b0};
    @(negedge clk);
    if (sel == 2) begin bi2 = b; bv2 = 1'b1; end
    else          begin bi8 = b; bv8 = 1'b1; end
    @(negedge clk);
    bv2 = 1'b0;
    bv8 = 1'b0;
    while (line(sel) !== 1'b0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != 2) begin
      failures++;
      $display("FAIL period%0d_latency got=%0d want=2", sel, n);
    end
    for (int i = 0; i < 10 * sel; i++) begin
      if (line(sel) !== fr[i / sel]) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0 || line(sel) !== 1'b1) begin
      failures++;
      $display("FAIL period%0d_%02h got=%0d bad cycles want=0",
               sel, b, bad);
    end
  endtask

  initial begin
    bi4 = '0; bi2 = '0; bi8 = '0;
    bv4 = 1'b0; bv2 = 1'b0; bv8 = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_full();
    test_reset_mid();
    test_bit_period(2, 8'h01);
    test_bit_period(2, 8'h80);
    test_bit_period(868, 8'h01);
    test_bit_period(868, 8'h80);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
